// File: rtl/signed_mult_core.sv
// Sequential 8x8 two's-complement multiplier: add/shift over {X,A,B}, the final step subtracts
// the multiplicand for the sign bit of B.
module signed_mult_core (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ClearA_LoadB,
    input  logic       Run,
    input  logic [7:0] S,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       X,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned W = 8;

    // ADDk states sit on even codes and SHFk on odd codes, so the sequence advances by +1
    typedef enum logic [4:0] {
        IDLE  = 5'd0,
        START = 5'd1,
        ADD0  = 5'd2,  SHF0,
        ADD1,  SHF1,
        ADD2,  SHF2,
        ADD3,  SHF3,
        ADD4,  SHF4,
        ADD5,  SHF5,
        ADD6,  SHF6,
        ADD7,  SHF7,
        HOLD
    } state_t;

    state_t       state_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] m_q;
    logic         x_q;
    logic         busy_q;
    logic         done_q;

    logic [W:0]   add_sum;
    logic [W:0]   sub_diff;

    // 9-bit sign-extended partial-product update
    always_comb begin
        add_sum  = {a_q[W-1], a_q} + {m_q[W-1], m_q};
        sub_diff = {a_q[W-1], a_q} - {m_q[W-1], m_q};
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!ClearA_LoadB) begin
                        a_q <= '0;
                        x_q <= 1'b0;
                        b_q <= S;
                    end else if (!Run) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    a_q     <= '0;
                    x_q     <= 1'b0;
                    m_q     <= S;
                    state_q <= ADD0;
                end
                HOLD: begin
                    if (Run) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    if (state_q > HOLD) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        if (!state_q[0]) begin
                            if (b_q[0]) begin
                                {x_q, a_q} <= (state_q == ADD7) ? sub_diff : add_sum;
                            end
                        end else begin
                            a_q <= {x_q, a_q[W-1:1]};
                            b_q <= {a_q[0], b_q[W-1:1]};
                        end
                        if (state_q == SHF7) begin
                            state_q <= HOLD;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= state_t'(state_q + 5'd1);
                        end
                    end
                end
            endcase
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_signed_mult_core.sv
// Self-checking bench for signed_mult_core: fixed vectors, corner sequences and random multiplies
// against a signed-arithmetic reference.
module tb_signed_mult_core;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       ClearA_LoadB;
    logic       Run;
    logic [7:0] S;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_b = 8'h00;

    typedef struct {
        logic [7:0]  b;
        logic [7:0]  s;
        logic [15:0] p;
    } vec_t;

    signed_mult_core dut (
        .Clk(Clk), .Reset(Reset), .ClearA_LoadB(ClearA_LoadB), .Run(Run), .S(S),
        .Aval(Aval), .Bval(Bval), .X(X), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        S = v;
        ClearA_LoadB = 1'b0;
        tick();
        ClearA_LoadB = 1'b1;
        model_b = v;
        check("load", {23'd0, Aval, X, Bval}, {23'd0, 8'h00, 1'b0, v});
    endtask

    // One multiply of s by the current B; optionally toggles controls while busy
    task automatic run_mult(input logic [7:0] s, input bit toggles, input int hold,
                            output logic [15:0] prod);
        int   p;
        int   nbusy;
        bit   done_seen;
        bit   a_moved;
        logic [7:0] b0;
        b0 = model_b;
        p = int'($signed(s)) * int'($signed(model_b));
        prod = 16'(p);
        nbusy = 0;
        done_seen = 1'b0;
        a_moved = 1'b0;
        S = s;
        ClearA_LoadB = 1'b1;
        Run = 1'b0;
        tick();
        for (int i = 0; i < 40 && !done_seen; i++) begin
            if (Done) begin
                done_seen = 1'b1;
            end else begin
                if (Busy) nbusy++;
                if (i >= 1) begin
                    S = 8'($urandom);
                    if (b0 == 8'h00 && Aval !== 8'h00) a_moved = 1'b1;
                end
                if (toggles) begin
                    ClearA_LoadB = 1'($urandom);
                    Run = 1'($urandom);
                end
                tick();
            end
        end
        Run = 1'b0;
        ClearA_LoadB = 1'b1;
        check("done_timeout", {31'd0, done_seen}, 32'd1);
        check("busy_cycles", 32'(nbusy), 32'd17);
        check("product", {15'd0, X, Aval, Bval}, {15'd0, prod[15], prod});
        if (b0 == 8'h00) check("a_static_when_b0", {31'd0, a_moved}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold", {14'd0, Done, Busy, Aval, Bval}, {14'd0, 1'b1, 1'b0, prod});
        end
        Run = 1'b1;
        tick();
        check("release", {30'd0, Done, Busy}, 32'd0);
        model_b = prod[7:0];
    endtask

    initial begin
        vec_t        vecs[8];
        logic [15:0] prod;

        vecs[0] = '{8'hFD, 8'h07, 16'hFFEB};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h00, 8'h5A, 16'h0000};
        vecs[3] = '{8'h02, 8'h03, 16'h0006};
        vecs[4] = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[5] = '{8'h80, 8'h7F, 16'hC080};
        vecs[6] = '{8'hFF, 8'hFF, 16'h0001};
        vecs[7] = '{8'h01, 8'h80, 16'hFF80};

        Reset = 1'b0;
        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        S = 8'hA5;
        tick();
        tick();
        check("reset_state", {13'd0, Aval, Bval, X, Busy, Done}, 32'd0);
        Reset = 1'b1;
        tick();
        check("idle_after_reset", {30'd0, Busy, Done}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            load(vecs[i].b);
            run_mult(vecs[i].s, 1'b0, 2, prod);
            check("table_vec", {15'd0, X, Aval, Bval}, {15'd0, vecs[i].p[15], vecs[i].p});
        end

        // back-to-back multiply reuses the low product byte as B
        load(8'h02);
        run_mult(8'h03, 1'b0, 0, prod);
        check("chain_first", {16'd0, prod}, 32'h0006);
        run_mult(8'h03, 1'b0, 0, prod);
        check("chain_second", {15'd0, X, Aval, Bval}, {15'd0, 1'b0, 16'h0012});

        // long Run press: one multiply only, Done held until release
        load(8'hC3);
        run_mult(8'h35, 1'b0, 40, prod);
        tick();
        check("no_restart", {30'd0, Busy, Done}, 32'd0);

        // both controls low in IDLE: load only, then start on the next cycle
        S = 8'h11;
        ClearA_LoadB = 1'b0;
        Run = 1'b0;
        tick();
        check("load_only", {22'd0, Busy, Aval, X, Bval}, {22'd0, 1'b0, 8'h00, 1'b0, 8'h11});
        model_b = 8'h11;
        run_mult(8'hF5, 1'b0, 1, prod);

        // reset in SHF3 with controls toggled during the sequence
        load(8'h5B);
        S = 8'h37;
        Run = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            ClearA_LoadB = 1'($urandom);
            Run = 1'($urandom);
            tick();
        end
        check("busy_in_shf3", {31'd0, Busy}, 32'd1);
        Reset = 1'b0;
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        tick();
        check("mid_reset", {13'd0, Aval, Bval, X, Busy, Done}, 32'd0);
        Reset = 1'b1;
        Run = 1'b1;
        ClearA_LoadB = 1'b1;
        tick();
        check("idle_after_mid_reset", {13'd0, Aval, Bval, X, Busy, Done}, 32'd0);
        model_b = 8'h00;

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) load(8'($urandom));
            run_mult(8'($urandom), 1'b1, $urandom_range(0, 3), prod);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
